display_scan: RTL and testbench

Output-side consumer of the board switch-decoder's `display_op` / `go` controls. It selects one of eight 32-bit CPU observation words and time-multiplexes it as 8 hex digits onto the board's common-anode 7-segment display. The selected word is captured once per scan frame so a digit never tears mid-frame. The block sits between the CPU debug taps (PC, RAM word at `ram_display_addr`, registers, cycle count, …) and the FPGA segment/anode pins.

---
 rtl/display_pkg.sv | 16 +
 rtl/hex_to_seg7.sv | 16 +
 rtl/display_scan.sv | 79 +++++++
 tb/tb_display_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display: hex decode table,
// dark-display codes and digit count.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active low, dp off
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low {g..a} segment pattern.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  logic [7:0] entry;

  always_comb begin
    entry = HEX_SEG[nibble];
    seg7  = entry[6:0];
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexes one of eight 32-bit observation words as 8 hex digits on a
// common-anode 7-segment display; the word is captured once per scan frame.
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 100_000,
  parameter bit LEAD_BLANK = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [2:0]   display_op,
  input  logic [255:0] disp_bus,
  output logic [7:0]   seg,
  output logic [7:0]   an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  logic       terminal;
  logic [3:0] nibble;
  logic [6:0] seg7;
  logic [31:0] upper;
  logic       blank;
  logic       dp_n;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg7   (seg7)
  );

  always_comb begin
    terminal   = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = terminal ? '0 : tick_cnt_q + 1'b1;
    idx_d      = terminal ? idx_q + 1'b1 : idx_q;
    shadow_d   = shadow_q;
    // Capture only at the frame boundary so a frame never mixes two words.
    if (terminal && (idx_q == IDX_LAST)) begin
      shadow_d = disp_bus[{display_op, 5'b0_0000} +: 32];
    end

    nibble = shadow_q[{idx_q, 2'b00} +: 4];
    upper  = shadow_q >> {idx_q, 2'b00};
    blank  = LEAD_BLANK && (idx_q != '0) && (upper == 32'h0);
    dp_n   = !((idx_q == '0) && !go);

    seg_d = {dp_n, blank ? 7'h7F : seg7};
    an_d  = ~(8'h01 << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan: two instances (plain and leading-blank)
// checked every cycle against a cycle-count based model of the scan.
module tb_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  localparam logic [7:0] HEX_T [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go = 1'b1;
  logic [2:0]   display_op = 3'd0;
  logic [255:0] disp_bus = '0;
  logic [7:0]   seg_a, an_a, seg_b, an_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int          ecount = 0;
  logic [31:0] mshadow = '0;
  logic [7:0]  exp_seg_a = 8'hFF, exp_seg_b = 8'hFF, exp_an = 8'hFF;
  int          m_d, m_sel;

  display_scan #(.SCAN_DIV(SCAN_DIV), .LEAD_BLANK(1'b0)) dut_a (
    .clk(clk), .rst(rst), .go(go), .display_op(display_op),
    .disp_bus(disp_bus), .seg(seg_a), .an(an_a)
  );

  display_scan #(.SCAN_DIV(SCAN_DIV), .LEAD_BLANK(1'b1)) dut_b (
    .clk(clk), .rst(rst), .go(go), .display_op(display_op),
    .disp_bus(disp_bus), .seg(seg_b), .an(an_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t, edge %0d)", name, act, exp, $time, ecount);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [31:0] w, input int d,
                                           input logic g, input bit lb);
    logic [31:0] up;
    logic [7:0]  s;
    up = w >> (4 * d);
    s  = HEX_T[up[3:0]];
    if (lb && d > 0 && up == 32'h0) s = 8'hFF;
    s[7] = (d == 0 && !g) ? 1'b0 : 1'b1;
    return s;
  endfunction

  // Outputs after edge N reflect state after N-1 edges: slot (N-1)/SCAN_DIV,
  // frame (N-1)/FRAME; the word captured at the edge ending each frame.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecount    = 0;
      mshadow   = '0;
      exp_seg_a = 8'hFF;
      exp_seg_b = 8'hFF;
      exp_an    = 8'hFF;
    end else begin
      m_d       = (ecount / SCAN_DIV) % 8;
      exp_an    = ~(8'h01 << m_d);
      exp_seg_a = model_seg(mshadow, m_d, go, 1'b0);
      exp_seg_b = model_seg(mshadow, m_d, go, 1'b1);
      if (ecount % FRAME == FRAME - 1) begin
        m_sel   = int'(display_op);
        mshadow = disp_bus[32 * m_sel +: 32];
      end
      ecount++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("seg_a", seg_a, exp_seg_a);
      check("an_a",  an_a,  exp_an);
      check("seg_b", seg_b, exp_seg_b);
      check("an_b",  an_b,  exp_an);
    end
  end

  task automatic goto(input int e);
    int n;
    n = 0;
    while (ecount != e && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ecount != e) begin
      n_fail++;
      $display("FAIL goto_timeout: at edge %0d waiting for edge %0d", ecount, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecount);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] frame_lit [8];
    int r, w;
    frame_lit = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

    for (int i = 0; i < 8; i++) disp_bus[32*i +: 32] = $urandom;
    disp_bus[31:0]   = 32'h89AB_CDEF;
    disp_bus[127:96] = 32'h1111_1111;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("reset_seg", seg_a, 8'hFF);
    check("reset_an", an_a, 8'hFF);
    #1 rst = 1'b0;

    goto(1);
    check("first_an", an_a, 8'hFE);
    check("first_seg", seg_a, 8'hC0);

    for (int i = 0; i < 8; i++) begin
      goto(33 + 4 * i);
      check("frame_digit", seg_a, frame_lit[i]);
      check("frame_an", an_a, ~(8'h01 << i));
      if (i == 2) display_op = 3'd3;
    end

    goto(65);
    check("sel_new_d0", seg_a, 8'hF9);
    goto(93);
    check("sel_new_d7", seg_a, 8'hF9);
    check("sel_new_an7", an_a, 8'h7F);

    goto(97);
    go = 1'b0;
    goto(98);
    check("pause_dp_d0", seg_a, 8'h79);
    check("pause_dp_an", an_a, 8'hFE);
    goto(100);
    disp_bus[191:160] = 32'h0000_0A05;
    disp_bus[223:192] = 32'h0;
    display_op = 3'd5;
    goto(101);
    check("pause_no_dp_d1", seg_a, 8'hF9);
    go = 1'b1;

    goto(129);
    check("lb_d0", seg_b, 8'h92);
    goto(133);
    check("lb_d1", seg_b, 8'hC0);
    goto(137);
    check("lb_d2", seg_b, 8'h88);
    goto(141);
    check("lb_d3", seg_b, 8'hFF);
    check("nolb_d3", seg_a, 8'hC0);
    goto(150);
    display_op = 3'd6;
    goto(157);
    check("lb_d7", seg_b, 8'hFF);
    goto(161);
    check("lb_zero_d0", seg_b, 8'hC0);
    goto(165);
    check("lb_zero_d1", seg_b, 8'hFF);
    goto(189);
    check("lb_zero_d7", seg_b, 8'hFF);

    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      if (r == 0) go = ~go;
      if (r == 1) display_op = 3'($urandom_range(0, 7));
      if (r <= 3) begin
        w = $urandom_range(0, 7);
        disp_bus[32*w +: 32] = $urandom >> $urandom_range(0, 31);
      end
    end

    go = 1'b1;
    begin
      int n;
      n = 0;
      while (((ecount / SCAN_DIV) % 8) != 5 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (((ecount / SCAN_DIV) % 8) != 5) begin
        n_fail++;
        $display("FAIL midreset_wait: idx slot not reached at edge %0d", ecount);
      end
    end
    #2 rst = 1'b1;
    #1;
    check("midreset_seg", seg_a, 8'hFF);
    check("midreset_an", an_a, 8'hFF);
    check("midreset_seg_b", seg_b, 8'hFF);
    @(negedge clk);
    #2 rst = 1'b0;
    goto(1);
    check("restart_seg", seg_a, 8'hC0);
    check("restart_an", an_a, 8'hFE);
    goto(21);
    check("restart_d5_seg", seg_a, 8'hC0);
    check("restart_d5_an", an_a, 8'hDF);
    check("restart_d5_lb", seg_b, 8'hFF);
    goto(40);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
